// File: rtl/latch_write_ctrl.sv
// latch_write_ctrl: sequences writes into a bank of level-sensitive D latches.
// Registered D bus plus a one-hot En pulse framed by setup and hold phases.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  write request present
//   req_ready  request can be accepted (IDLE and not in reset)
//   req_addr   target latch index (AW bits)
//   req_data   data to write (DW bits)
//   D          registered data bus to every latch
//   En         registered one-hot latch enables (N_LATCH bits)
//   busy       a write is in progress
//   err        one-cycle pulse on an out-of-range address
module latch_write_ctrl #(
  parameter int N_LATCH   = 4,
  parameter int DW        = 8,
  parameter int AW        = $clog2(N_LATCH),
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [AW-1:0]      req_addr,
  input  logic [DW-1:0]      req_data,
  output logic [DW-1:0]      D,
  output logic [N_LATCH-1:0] En,
  output logic               busy,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD
  } state_t;

  localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAXC   = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CW     = $clog2(MAXC + 1);

  localparam logic [CW-1:0] S_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] H_LAST = CW'(HOLD_CYC - 1);

  localparam logic [N_LATCH-1:0] ONE = {{(N_LATCH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        d_q, d_d;
  logic [N_LATCH-1:0]   en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 in_range;

  // Widened compare so a power-of-two bank does not fold to a constant.
  assign in_range = 32'(req_addr) < 32'(N_LATCH);

  assign req_ready = (state_q == IDLE) && !rst;
  assign D         = d_q;
  assign En        = en_q;
  assign busy      = busy_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    d_d     = d_q;
    en_d    = en_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (in_range) begin
            addr_d  = req_addr;
            d_d     = req_data;
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt_q == S_LAST) begin
          cnt_d   = '0;
          en_d    = ONE << addr_q;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == P_LAST) begin
          cnt_d   = '0;
          en_d    = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == H_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        en_d    = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      d_q     <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      d_q     <= d_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_latch_write_ctrl.sv
// tb_latch_write_ctrl: scoreboard bench for latch_write_ctrl.
// Reference model tracks accepted writes by cycle number and a latch image.
module tb_latch_write_ctrl;

  localparam int S = 1;
  localparam int P = 2;
  localparam int H = 1;

  typedef struct {
    int addr;
    int data;
    int k;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       req_ready, busy, err;
  logic [7:0] D;
  logic [3:0] En;

  logic       rst3 = 1'b1;
  logic       v3 = 1'b0;
  logic [1:0] a3 = '0;
  logic [7:0] d3 = '0;
  logic       rdy3, busy3, err3;
  logic [7:0] D3;
  logic [2:0] En3;

  latch_write_ctrl #(
    .N_LATCH(4), .DW(8),
    .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .D(D), .En(En), .busy(busy), .err(err)
  );

  latch_write_ctrl #(
    .N_LATCH(3), .DW(8),
    .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)
  ) dut3 (
    .clk(clk), .rst(rst3),
    .req_valid(v3), .req_ready(rdy3),
    .req_addr(a3), .req_data(d3),
    .D(D3), .En(En3), .busy(busy3), .err(err3)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string n, input int act, input int exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", n, act, exp_v, $time);
    end
  endtask

  // Cycle index: number of rising edges seen so far.
  int   cyc = 0;
  logic rst_edge = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  // Behavioural latch bank: transparent while its En bit is high.
  logic [7:0] lq [4] = '{default: 8'h00};
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (En[i]) lq[i] <= D;
  end

  // Reference model state.
  wr_t        sbq[$];
  bit         have = 1'b0;
  int         k_acc = 0;
  logic [7:0] exp_d = 8'h00;
  logic [7:0] exp_mem [4] = '{default: 8'h00};
  bit         in_pulse = 1'b0;
  int         p_start = 0;
  int         p_addr = 0;
  logic [7:0] prev_d = 8'h00;
  wr_t        w;

  function automatic bit m_busy();
    return have && cyc >= k_acc && cyc <= k_acc + S + P + H - 1;
  endfunction

  function automatic bit m_ready();
    return !rst && !m_busy();
  endfunction

  // Monitor: compares every cycle, pops the scoreboard on each En pulse.
  always @(negedge clk) begin
    if (rst_edge) begin
      chk("rst_d", D, 0);
      chk("rst_en", En, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_ready", req_ready, !rst);
      in_pulse = 1'b0;
      exp_d = 8'h00;
    end else begin
      if (sbq.size() > 0 && sbq[0].k == cyc) exp_d = 8'(sbq[0].data);
      chk("d", D, exp_d);
      chk("busy", busy, m_busy());
      chk("ready", req_ready, m_ready());
      chk("err", err, 0);
      chk("onehot", $countones(En) <= 1, 1);
      if (En != 0) chk("d_stable", D, prev_d);
      if (En != 0 && !in_pulse) begin
        if (sbq.size() == 0) begin
          chk("spurious_en", En, 0);
        end else begin
          w = sbq.pop_front();
          chk("en_bit", En, 1 << w.addr);
          chk("en_start", cyc, w.k + S);
          in_pulse = 1'b1;
          p_start = cyc;
          p_addr = w.addr;
          exp_mem[w.addr] = 8'(w.data);
        end
      end else if (En == 0 && in_pulse) begin
        chk("en_len", cyc - p_start, P);
        in_pulse = 1'b0;
        for (int i = 0; i < 4; i++) chk("latch_q", lq[i], exp_mem[i]);
      end else if (in_pulse) begin
        chk("en_hold", En, 1 << p_addr);
      end
    end
    prev_d = D;
  end

  task automatic step(input bit v, input logic [1:0] a,
                      input logic [7:0] d, output bit acc);
    @(posedge clk);
    #1;
    req_valid = v;
    req_addr = a;
    req_data = d;
    #1;
    acc = v && m_ready();
    if (acc) begin
      sbq.push_back('{addr: int'(a), data: int'(d), k: cyc + 1});
      have = 1'b1;
      k_acc = cyc + 1;
    end
  endtask

  task automatic send(input logic [1:0] a, input logic [7:0] d);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 20) begin
      step(1'b1, a, d, acc);
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: addr %0d not accepted in 20 cycles", a);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) step(1'b0, 2'($urandom), 8'($urandom), acc);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    rst3 = 1'b0;
    req_valid = 1'b0;
    sbq.delete();
    have = 1'b0;
  endtask

  initial begin
    bit acc;
    int ea;
    do_reset(3);
    idle(2);
    send(2'd2, 8'hA5);
    idle(6);
    send(2'd0, 8'h11);
    send(2'd3, 8'h22);
    idle(6);
    send(2'd1, 8'h3C);
    repeat (4) step(1'b1, 2'd0, 8'hFF, acc);
    idle(4);
    send(2'd1, 8'h5A);
    idle(S);
    do_reset(1);
    idle(3);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) do_reset($urandom_range(1, 2));
      else step($urandom_range(9) < 7, 2'($urandom), 8'($urandom), acc);
    end
    idle(10);
    total++;
    if (sbq.size() != 0 || in_pulse) begin
      bad++;
      $display("FAIL drain: %0d writes never pulsed", sbq.size());
    end

    // Three-latch bank: address 3 is out of range.
    @(posedge clk);
    #1;
    v3 = 1'b1;
    a3 = 2'd3;
    d3 = 8'h99;
    @(posedge clk);
    #1;
    a3 = 2'd1;
    d3 = 8'h3C;
    @(negedge clk);
    chk("n3_err", err3, 1);
    chk("n3_err_en", En3, 0);
    chk("n3_err_d", D3, 0);
    chk("n3_err_busy", busy3, 0);
    chk("n3_ready", rdy3, 1);
    @(posedge clk);
    #1;
    ea = cyc;
    v3 = 1'b0;
    a3 = 2'd0;
    d3 = 8'hFF;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("n3_err_low", err3, 0);
      chk("n3_d", D3, 8'h3C);
      chk("n3_en", En3, (j >= S && j < S + P) ? 3'b010 : 3'b000);
      chk("n3_busy", busy3, j < S + P + H);
      chk("n3_rdy", rdy3, !(j < S + P + H));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/latch_write_ctrl.md
Name: latch_write_ctrl

Overview:
- Clocked write sequencer that drives the D/En inputs of a bank of level-sensitive D latches.
- Accepts write requests over a valid/ready handshake and drives a registered D bus.
- Drives a glitch-free one-hot En pulse with programmable setup, pulse and hold phases, so latch data is always stable around the transparent window.
- Sits directly upstream of the D_Latch bank.

Parameters:
- N_LATCH, 4, number of latches in the bank (one En bit each); legal range 2..16.
- DW, 8, width of the D bus and request data.
- AW, $clog2(N_LATCH), derived request address width; not overridden.
- SETUP_CYC, 1, cycles D is stable before En rises; minimum 1.
- PULSE_CYC, 2, cycles En stays high; minimum 1.
- HOLD_CYC, 1, cycles D stays stable after En falls; minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  write request present.
- req_ready  output  1  controller can accept a request.
- req_addr  input  AW  target latch index.
- req_data  input  DW  data to write.
- D  output  DW  registered data bus to all latches.
- En  output  N_LATCH  registered one-hot latch enables.
- busy  output  1  high while a write is in progress.
- err  output  1  one-cycle pulse: out-of-range address.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, D=0, En=0, busy=0, err=0, cnt=0. req_ready=0 whenever rst=1.
- rst overrides everything, including mid-write: En drops to 0 at that edge and the in-flight write is abandoned.
- States: IDLE, SETUP, PULSE, HOLD.
- req_ready = (state==IDLE) && !rst; it is combinational from state. Acceptance = req_valid && req_ready at a rising edge.
- IDLE + accept, req_addr < N_LATCH:
  - capture addr; D <= req_data; busy <= 1; cnt <= 0; go to SETUP.
- IDLE + accept, req_addr >= N_LATCH:
  - err <= 1 for exactly one cycle; D and En unchanged; stay in IDLE.
  - A new request may be accepted on the next edge.
- SETUP: En=0. After SETUP_CYC cycles, En[addr] <= 1 and go to PULSE.
- PULSE: exactly one En bit is high. After PULSE_CYC cycles, En <= 0 and go to HOLD.
- HOLD: En=0, D held. After HOLD_CYC cycles, busy <= 0 and go to IDLE.
- Timing for an accept at edge k, with S/P/H = setup/pulse/hold cycles:
  - D valid from k+1.
  - En[addr] high during cycles k+S+1 .. k+S+P.
  - req_ready high again at cycle k+S+P+H+1.
- Throughput: one write per S+P+H+1 cycles. No accept occurs while busy.
- D changes only on an in-range accept or on reset. In IDLE, D keeps the last written value.
- req_data/req_addr changes while busy have no effect on D, En or the target latch.
- Invariants:
  - At most one En bit is high at any time.
  - En is never high in the same cycle as a D change.
  - En outputs are flop-driven, so they are glitch-free.
- cnt is wide enough for max(SETUP_CYC, PULSE_CYC, HOLD_CYC). It resets to 0 on each state change and never wraps within a phase.

Test Plan:
(Defaults N_LATCH=4, DW=8, S/P/H=1/2/1 unless noted. Bench instantiates a behavioural latch model per En bit and checks each Q.)
1. Reset: hold rst=1 for 3 cycles with req_valid=1 -> D=0x00, En=0000, busy=0, req_ready=0. After release, req_ready=1 and no write has occurred.
2. Single write addr=2, data=0xA5 -> D=0xA5 from the next cycle; En=0100 for exactly 2 cycles starting 2 cycles after accept; busy high for 4 cycles; latch2 Q=0xA5, other Q unchanged.
3. Back-to-back: req_valid held with addr0/0x11, then addr3/0x22 -> second accept exactly 5 cycles after the first; En sequence 0001,0001 then 1000,1000; never two bits high.
4. While busy on addr1/0x3C, toggle req_data=0xFF and req_addr=0 -> D stays 0x3C, only En[1] pulses, latch0 Q unchanged.
5. N_LATCH=3, request addr=3 -> err=1 for one cycle, En=000, D unchanged; a following addr=1 write completes normally.
6. Assert rst in the 1st PULSE cycle of a write to addr=1 -> En=0000 and D=0x00 at the next edge, state IDLE, req_ready=1 after rst falls.
